// File: rtl/lsu_pkg.sv
// lsu_pkg: memory-op codes, FSM state encoding and access-decode helpers shared by the LSU.
package lsu_pkg;
  localparam logic [3:0] LB  = 4'h0;
  localparam logic [3:0] LH  = 4'h1;
  localparam logic [3:0] LW  = 4'h2;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] SB  = 4'h8;
  localparam logic [3:0] SH  = 4'h9;
  localparam logic [3:0] SW  = 4'hA;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  // Unknown codes fall through to LW, so only the three defined store codes write.
  function automatic logic is_store(input logic [3:0] op);
    return op == SB || op == SH || op == SW;
  endfunction
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    return (op == LB || op == LBU || op == SB) ? 1'b0 :
           (op == LH || op == LHU || op == SH) ? a[0] : |a;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
// Ports: rdata (read word), offset (addr[1:0]), op (mem_op), data (extended result).
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  op,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];
  assign data = op == LB  ? {{24{b[7]}}, b}  :
                op == LBU ? {24'h0, b}       :
                op == LH  ? {{16{h[15]}}, h} :
                op == LHU ? {16'h0, h}       : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit over a req/gnt/rvalid memory port.
// Ports: clk/rst; request side req_valid/req_ready/addr/wdata/mem_op;
// response side resp_valid/rdata/misalign; memory side mem_req/mem_we/mem_addr/
// mem_wdata/mem_wstrb/mem_gnt/mem_rvalid/mem_rdata.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mem_op,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_t      state;
  logic [31:0] a, wd, ld_data;
  logic [3:0]  op;
  load_align u_align (.rdata(mem_rdata), .offset(a[1:0]), .op(op), .data(ld_data));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      wd       <= '0;
      op       <= '0;
      rdata    <= '0;
      misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a  <= addr;
          wd <= wdata;
          op <= mem_op;
          if (is_misaligned(mem_op, addr[1:0])) begin
            state    <= RESP;
            rdata    <= '0;
            misalign <= 1'b1;
          end else state <= REQ;
        end
        REQ: if (mem_gnt) begin
          if (is_store(op)) begin
            state    <= RESP;
            rdata    <= '0;
            misalign <= 1'b0;
          end else state <= WAIT;
        end
        WAIT: if (mem_rvalid) begin
          state    <= RESP;
          rdata    <= ld_data;
          misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Memory-side fields are decoded from the latched request and forced to 0 outside REQ.
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_req    = state == REQ;
  assign mem_we     = mem_req && is_store(op);
  assign mem_addr   = mem_req ? {a[31:2], 2'b00} : '0;
  assign mem_wdata  = !mem_req ? '0 : op == SB ? {4{wd[7:0]}} : op == SH ? {2{wd[15:0]}} : wd;
  assign mem_wstrb  = !mem_we ? 4'b0000 : op == SB ? 4'b0001 << a[1:0] :
                      op == SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a byte-level memory reference model.
module tb_lsu;
  import lsu_pkg::*;
  logic        clk = 1'b0;
  logic        rst, req_valid, mem_gnt, mem_rvalid;
  logic [31:0] addr, wdata, mem_rdata;
  logic [3:0]  mem_op;
  logic        req_ready, resp_valid, misalign, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_model [16];
  logic [31:0] last_rd;
  logic        last_mis;
  int n_chk = 0, n_err = 0;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .wdata(wdata), .mem_op(mem_op), .resp_valid(resp_valid), .rdata(rdata),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_resp"}, resp_valid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_mis"}, misalign, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_mwdata"}, mem_wdata, 0);
    check({tag, "_wstrb"}, mem_wstrb, 0);
  endtask

  // One complete access, starting #1 after a rising edge with the DUT idle and
  // ending #1 after the edge that leaves RESP (the next request can go out at once).
  task automatic access(input logic [3:0] op, input logic [31:0] ad, input logic [31:0] wd,
                        input int gd, input int rd);
    int size, off, idx;
    bit st, sgn, mis;
    longint v;
    logic [31:0] exp_rd, exp_wd, word;
    logic [3:0] exp_st;
    st   = op == SB || op == SH || op == SW;
    sgn  = op == LB || op == LH;
    size = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    off  = int'(ad[1:0]);
    idx  = int'(ad[5:2]);
    mis  = (off % size) != 0;
    exp_st = '0;
    exp_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (st && !mis && i >= off && i < off + size) exp_st[i] = 1'b1;
      exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    word = mem_model[idx];
    v = (longint'(word) >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
    if (sgn && v[8*size-1]) v = v - (64'sd1 <<< (8 * size));
    exp_rd = (mis || st) ? 32'h0 : v[31:0];
    req_valid = 1'b1; addr = ad; wdata = wd; mem_op = op;
    mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_req", mem_req, 0);
    check("idle_resp", resp_valid, 0);
    check("hold_rdata", rdata, last_rd);
    check("hold_mis", misalign, last_mis);
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; mem_op = 4'($urandom);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (mis) begin
      @(negedge clk);
      check("mis_resp", resp_valid, 1);
      check("mis_flag", misalign, 1);
      check("mis_rdata", rdata, 0);
      check("mis_req", mem_req, 0);
      check("mis_ready", req_ready, 0);
    end else begin
      for (int g = 0; g <= gd; g++) begin
        mem_gnt = g == gd;
        mem_rvalid = 1'($urandom);
        @(negedge clk);
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, ad & 32'hFFFF_FFFC);
        check("mem_we", mem_we, st);
        check("mem_wstrb", mem_wstrb, exp_st);
        if (st) check("mem_wdata", mem_wdata, exp_wd);
        check("req_resp", resp_valid, 0);
        check("req_ready", req_ready, 0);
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) if (exp_st[i]) mem_model[idx][8*i +: 8] = exp_wd[8*i +: 8];
      if (!st) begin
        for (int w = 0; w <= rd; w++) begin
          mem_rvalid = w == rd;
          mem_gnt = 1'($urandom);
          mem_rdata = (w == rd) ? word : $urandom;
          @(negedge clk);
          check("wait_req", mem_req, 0);
          check("wait_resp", resp_valid, 0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
      end
      @(negedge clk);
      check("resp_valid", resp_valid, 1);
      check("resp_rdata", rdata, exp_rd);
      check("resp_mis", misalign, 0);
      check("resp_req", mem_req, 0);
    end
    last_rd = exp_rd;
    last_mis = mis;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] sw_word;
    rst = 1'b1; req_valid = 1'b0; addr = '0; wdata = '0; mem_op = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    last_rd = '0; last_mis = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    access(SB, 32'h1003, 32'h0000_00AB, 0, 0);
    mem_model[0] = 32'h1234_F678;
    access(LB, 32'h2001, 32'h0, 0, 0);
    access(LBU, 32'h2001, 32'h0, 0, 0);
    mem_model[0] = 32'h8001_1234;
    access(LH, 32'h3002, 32'h0, 3, 2);
    access(LW, 32'h4002, 32'h0, 0, 0);
    access(SH, 32'h4001, 32'hDEAD_BEEF, 0, 0);
    // Reset while a load is outstanding in WAIT; the late rvalid must be dropped.
    req_valid = 1'b1; addr = 32'h6000; mem_op = LW;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_rv_resp", resp_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rv_resp2", resp_valid, 0);
    check("late_rv_ready", req_ready, 1);
    check("late_rv_rdata", rdata, 0);
    @(posedge clk); #1;
    last_rd = '0; last_mis = 1'b0;
    sw_word = $urandom;
    access(SW, 32'h5000, sw_word, 0, 0);
    access(LW, 32'h5000, 32'h0, 0, 0);
    check("b2b_word", rdata, sw_word);
    for (int n = 0; n < 250; n++)
      access(4'($urandom_range(0, 15)), 32'h7000 | 32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
